pipeline_hazard_controller: RTL and testbench

Central stall/flush sequencer for the five-stage in-order pipeline (IF, ID, EX, MA, WB). Each cycle it decides, for every pipeline register (Decode, Execute, MemoryAccess and WriteBack stage regs), whether that register loads, holds, or loads a bubble. It resolves:

- load-use hazards,
- branch/next-PC mispredicts,
- data-memory wait states,
- the halt drain sequence.

It also keeps stall and flush performance counters.

---
 rtl/pipeline_hazard_controller.sv | 150 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the five-stage in-order pipeline.
// Resolves memory wait states, EX mispredicts, halt drain and load-use
// hazards with a fixed priority, and keeps saturating stall/flush counters.
module pipeline_hazard_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       idRs1Addr,
  input  logic [4:0]       idRs2Addr,
  input  logic             idUsesRs1,
  input  logic             idUsesRs2,
  input  logic [4:0]       exRdAddr,
  input  logic             exRdWrite,
  input  logic             exIsLoad,
  input  logic             exMispredict,
  input  logic             exIsHalt,
  input  logic             maMemAccess,
  input  logic             dmemReady,
  output logic             dmemReq,
  output logic             pcStall,
  output logic             idStall,
  output logic             exStall,
  output logic             maStall,
  output logic             idFlush,
  output logic             exFlush,
  output logic             maFlush,
  output logic             wbFlush,
  output logic             pcRedirect,
  output logic             halted,
  output logic [CNT_W-1:0] stallCycles,
  output logic [CNT_W-1:0] flushCount
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} halt_state_t;
  typedef enum logic       {MEM_IDLE, MEM_WAIT} mem_state_t;

  halt_state_t halt_state, halt_next;
  mem_state_t  mem_state, mem_next;
  logic [1:0]  drain_cnt, drain_next;

  logic mem_wait, load_use, rs1_hit, rs2_hit;
  logic stall_inc, flush_inc;

  assign mem_wait = maMemAccess & ~dmemReady;
  assign rs1_hit  = idUsesRs1 & (idRs1Addr == exRdAddr);
  assign rs2_hit  = idUsesRs2 & (idRs2Addr == exRdAddr);
  assign load_use = exIsLoad & exRdWrite & (exRdAddr != 5'd0) & (rs1_hit | rs2_hit);

  // The request simply tracks the MA access; it drops once the access completes
  // because MA advances and the access signal goes away.
  assign dmemReq = maMemAccess;

  // Memory FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_state <= MEM_IDLE;
    else     mem_state <= mem_next;
  end

  // Memory FSM next state (tracks outstanding waits; stall decisions use mem_wait)
  always_comb begin
    mem_next = mem_state;
    case (mem_state)
      MEM_IDLE: if (mem_wait)  mem_next = MEM_WAIT;
      MEM_WAIT: if (dmemReady) mem_next = MEM_IDLE;
      default:                 mem_next = MEM_IDLE;
    endcase
  end

  // Halt FSM and drain counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_state <= RUN;
      drain_cnt  <= 2'd0;
    end else begin
      halt_state <= halt_next;
      drain_cnt  <= drain_next;
    end
  end

  // Prioritised stall/flush decision and halt FSM next state
  always_comb begin
    halt_next  = halt_state;
    drain_next = drain_cnt;
    pcStall    = 1'b0;
    idStall    = 1'b0;
    exStall    = 1'b0;
    maStall    = 1'b0;
    idFlush    = 1'b0;
    exFlush    = 1'b0;
    maFlush    = 1'b0;
    wbFlush    = 1'b0;
    pcRedirect = 1'b0;
    halted     = 1'b0;
    if (halt_state == HALTED) begin
      // Frozen core: hold everything, keep WB empty.
      halted  = 1'b1;
      pcStall = 1'b1;
      idStall = 1'b1;
      exStall = 1'b1;
      maStall = 1'b1;
      wbFlush = 1'b1;
    end else if (mem_wait) begin
      // Hold IF..MA behind the pending access; EX events wait with EX.
      pcStall = 1'b1;
      idStall = 1'b1;
      exStall = 1'b1;
      maStall = 1'b1;
      wbFlush = 1'b1;
    end else if (halt_state == DRAIN) begin
      // Let MA/WB retire the older instructions and the halt itself.
      pcStall = 1'b1;
      idFlush = 1'b1;
      exFlush = 1'b1;
      if (drain_cnt == 2'd0) halt_next  = HALTED;
      else                   drain_next = drain_cnt - 2'd1;
    end else if (exMispredict) begin
      // Squash the two wrong-path instructions; this also covers load-use.
      pcRedirect = 1'b1;
      idFlush    = 1'b1;
      exFlush    = 1'b1;
    end else if (exIsHalt) begin
      pcStall    = 1'b1;
      idFlush    = 1'b1;
      exFlush    = 1'b1;
      halt_next  = DRAIN;
      drain_next = 2'd2;
    end else if (load_use) begin
      // One bubble so the load data can be forwarded from MA.
      pcStall = 1'b1;
      idStall = 1'b1;
      exFlush = 1'b1;
    end
  end

  assign stall_inc = pcStall & (halt_state == RUN);
  assign flush_inc = exMispredict & ~mem_wait;

  // Saturating performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (stall_inc && (stallCycles != '1)) stallCycles <= stallCycles + CNT_W'(1);
      if (flush_inc && (flushCount  != '1)) flushCount  <= flushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: two DUT copies (32-bit and 4-bit counters) share the
// stimulus and are compared every cycle against a behavioural model.
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] idRs1Addr, idRs2Addr, exRdAddr;
  logic idUsesRs1, idUsesRs2, exRdWrite, exIsLoad, exMispredict, exIsHalt;
  logic maMemAccess, dmemReady;

  logic dmemReq, pcStall, idStall, exStall, maStall;
  logic idFlush, exFlush, maFlush, wbFlush, pcRedirect, halted;
  logic [31:0] stallCycles, flushCount;

  logic dmemReq4, pcStall4, idStall4, exStall4, maStall4;
  logic idFlush4, exFlush4, maFlush4, wbFlush4, pcRedirect4, halted4;
  logic [3:0] stallCycles4, flushCount4;

  pipeline_hazard_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .idRs1Addr(idRs1Addr), .idRs2Addr(idRs2Addr),
    .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .exRdAddr(exRdAddr), .exRdWrite(exRdWrite), .exIsLoad(exIsLoad),
    .exMispredict(exMispredict), .exIsHalt(exIsHalt),
    .maMemAccess(maMemAccess), .dmemReady(dmemReady),
    .dmemReq(dmemReq), .pcStall(pcStall), .idStall(idStall), .exStall(exStall),
    .maStall(maStall), .idFlush(idFlush), .exFlush(exFlush), .maFlush(maFlush),
    .wbFlush(wbFlush), .pcRedirect(pcRedirect), .halted(halted),
    .stallCycles(stallCycles), .flushCount(flushCount)
  );

  pipeline_hazard_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .idRs1Addr(idRs1Addr), .idRs2Addr(idRs2Addr),
    .idUsesRs1(idUsesRs1), .idUsesRs2(idUsesRs2),
    .exRdAddr(exRdAddr), .exRdWrite(exRdWrite), .exIsLoad(exIsLoad),
    .exMispredict(exMispredict), .exIsHalt(exIsHalt),
    .maMemAccess(maMemAccess), .dmemReady(dmemReady),
    .dmemReq(dmemReq4), .pcStall(pcStall4), .idStall(idStall4), .exStall(exStall4),
    .maStall(maStall4), .idFlush(idFlush4), .exFlush(exFlush4), .maFlush(maFlush4),
    .wbFlush(wbFlush4), .pcRedirect(pcRedirect4), .halted(halted4),
    .stallCycles(stallCycles4), .flushCount(flushCount4)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: edges left until halted (0 = not draining), halted flag, counters.
  int      m_left;
  bit      m_halted;
  longint  m_stall, m_flush, m_stall4, m_flush4;
  bit      e_mw, e_stall_en, e_flush_en, e_enter;
  logic [10:0] e_vec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_halted = 0;
    m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
  endtask

  // Expected outputs from the priority rules; vector order is
  // {dmemReq,pcStall,idStall,exStall,maStall,idFlush,exFlush,maFlush,wbFlush,pcRedirect,halted}
  task automatic compute_exp();
    bit lu, drain, pc, ids, exs, mas, idf, exf, wbf, red;
    lu = exIsLoad && exRdWrite && exRdAddr != 0 &&
         ((idUsesRs1 && idRs1Addr == exRdAddr) || (idUsesRs2 && idRs2Addr == exRdAddr));
    e_mw  = maMemAccess && !dmemReady;
    drain = m_left > 0;
    {pc, ids, exs, mas, idf, exf, wbf, red} = '0;
    e_enter = 0;
    if (m_halted || e_mw)      {pc, ids, exs, mas, wbf} = 5'b11111;
    else if (drain)            {pc, idf, exf} = 3'b111;
    else if (exMispredict)     {red, idf, exf} = 3'b111;
    else if (exIsHalt) begin   {pc, idf, exf} = 3'b111; e_enter = 1; end
    else if (lu)               {pc, ids, exf} = 3'b111;
    e_vec = {maMemAccess, pc, ids, exs, mas, idf, exf, 1'b0, wbf, red, m_halted};
    e_stall_en = pc && !m_halted && !drain;
    e_flush_en = exMispredict && !e_mw;
  endtask

  task automatic check_all();
    compute_exp();
    chk("outs", {dmemReq, pcStall, idStall, exStall, maStall, idFlush, exFlush,
                 maFlush, wbFlush, pcRedirect, halted}, e_vec);
    chk("outs4", {dmemReq4, pcStall4, idStall4, exStall4, maStall4, idFlush4, exFlush4,
                  maFlush4, wbFlush4, pcRedirect4, halted4}, e_vec);
    chk("stallCycles", stallCycles, m_stall);
    chk("flushCount", flushCount, m_flush);
    chk("stallCycles4", stallCycles4, m_stall4);
    chk("flushCount4", flushCount4, m_flush4);
  endtask

  task automatic model_edge();
    if (e_stall_en) begin
      if (m_stall < 64'hFFFF_FFFF) m_stall++;
      if (m_stall4 < 15) m_stall4++;
    end
    if (e_flush_en) begin
      if (m_flush < 64'hFFFF_FFFF) m_flush++;
      if (m_flush4 < 15) m_flush4++;
    end
    if (m_left > 0 && !e_mw) begin
      m_left--;
      if (m_left == 0) m_halted = 1;
    end
    if (e_enter) m_left = 3;
  endtask

  // Called at a negedge with inputs already set.
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    idRs1Addr = 0; idRs2Addr = 0; idUsesRs1 = 0; idUsesRs2 = 0;
    exRdAddr = 0; exRdWrite = 0; exIsLoad = 0; exMispredict = 0; exIsHalt = 0;
    maMemAccess = 0; dmemReady = 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // EX: lw x5 ; ID: add x6, x5, x1
  task automatic set_load_use();
    idle();
    exIsLoad = 1; exRdWrite = 1; exRdAddr = 5;
    idUsesRs1 = 1; idRs1Addr = 5; idUsesRs2 = 1; idRs2Addr = 1;
  endtask

  task automatic rand_inputs();
    idRs1Addr    = 5'($urandom_range(0, 3));
    idRs2Addr    = 5'($urandom_range(0, 3));
    exRdAddr     = 5'($urandom_range(0, 3));
    idUsesRs1    = 1'($urandom_range(0, 1));
    idUsesRs2    = 1'($urandom_range(0, 1));
    exRdWrite    = ($urandom_range(0, 3) != 0);
    exIsLoad     = 1'($urandom_range(0, 1));
    exMispredict = ($urandom_range(0, 7) == 0);
    exIsHalt     = ($urandom_range(0, 29) == 0);
    maMemAccess  = ($urandom_range(0, 2) == 0);
    dmemReady    = ($urandom_range(0, 9) < 7);
  endtask

  initial begin
    int edges;
    idle();
    @(negedge clk);
    do_reset();
    chk("rst_halted", halted, 0);
    chk("rst_stall", stallCycles, 0);

    // Load-use: one bubble, then clear
    set_load_use();
    #1 chk("lu_bubble", {pcStall, idStall, exFlush, exStall}, 4'b1110);
    cycle();
    idle();
    #1 chk("lu_clear", pcStall, 0);
    chk("lu_count", stallCycles, 1);
    set_load_use(); exRdAddr = 0; idRs1Addr = 0;
    #1 chk("lu_x0", pcStall, 0);
    cycle();

    // Mispredict together with load-use
    set_load_use(); exMispredict = 1;
    #1 chk("mis_lu", {pcRedirect, idFlush, exFlush, idStall}, 4'b1110);
    cycle();
    idle();
    #1 chk("mis_cnt", flushCount, 1);

    // Memory wait with pending mispredict
    do_reset();
    idle(); maMemAccess = 1; dmemReady = 0; exMispredict = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mw_stall", {pcStall, idStall, exStall, maStall, wbFlush, dmemReq, pcRedirect}, 7'b1111110);
      cycle();
    end
    chk("mw_noflush", flushCount, 0);
    dmemReady = 1;
    #1 chk("mw_done", {pcRedirect, pcStall, dmemReq}, 3'b101);
    cycle();
    idle();
    #1 chk("mw_flushcnt", flushCount, 1);
    chk("mw_stallcnt", stallCycles, 3);

    // Halt without memWait: 3 edges after entry
    do_reset();
    idle(); exIsHalt = 1;
    cycle();
    idle();
    edges = 0;
    while (!halted && edges < 10) begin cycle(); edges++; end
    chk("halt_edges", edges, 3);

    // Halt with 2 memWait cycles in DRAIN
    do_reset();
    idle(); exIsHalt = 1;
    cycle();
    idle();
    cycle();
    maMemAccess = 1; dmemReady = 0;
    cycle(); cycle();
    idle();
    edges = 3;
    while (!halted && edges < 12) begin cycle(); edges++; end
    chk("halt_mw_edges", edges, 5);
    exIsHalt = 1;
    #1 chk("halted_hold", {halted, pcStall, idFlush}, 3'b110);
    cycle();
    idle();

    // Reset mid-DRAIN with a pending access
    do_reset();
    idle(); exIsHalt = 1;
    cycle();
    idle(); maMemAccess = 1; dmemReady = 0;
    #2 rst = 1'b1;
    #1 model_reset();
    chk("rst_mid_req", dmemReq, 1);
    idle();
    #1 chk("rst_mid", {halted, pcStall, dmemReq}, 3'b000);
    chk("rst_mid_cnt", stallCycles, 0);
    @(negedge clk);
    rst = 1'b0;

    // Saturation: 20 load-use stall cycles
    do_reset();
    set_load_use();
    for (int i = 0; i < 20; i++) cycle();
    idle();
    #1 chk("sat4", stallCycles4, 15);
    chk("sat32", stallCycles, 20);

    // Randomised traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        idle();
        do_reset();
      end
      rand_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
